prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream loader that writes the micro's program (ROM) and data (RAM) images from a host link, then releases the micro from reset.
- Write-side counterpart of the micro's read-only ROM/RAM fetch interface.
- Sits between a host byte source (UART/JTAG bridge) and the write ports of rom_memory/ram_memory.
- Also drives the micro's arst so the core never runs while memory is being loaded.

Parameters:
ADDR_W, 8, memory address width; addresses wrap modulo 2**ADDR_W
DATA_W, 8, byte width of stream, memory data and length field

Ports:
clk  input  1  system clock, rising edge
arst  input  1  asynchronous reset, active-low
in_data  input  DATA_W  host stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts in_data; a transfer occurs when in_valid & in_ready at a rising clk edge
mem_sel  output  1  0 = ROM target, 1 = RAM target; valid while wr_en
wr_addr  output  ADDR_W  write address
wr_data  output  DATA_W  write data
wr_en  output  1  one-cycle write strobe
micro_rst  output  1  active-high reset to micro (drives its arst)
busy  output  1  high in every state except IDLE
err  output  1  sticky protocol error flag

Behaviour:
- Reset (arst low): state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, mem_sel=0, micro_rst=1, busy=0, err=0. in_ready rises on the first clk edge after arst deasserts and is high in every state thereafter.
- Frame format: CMD, then for a load: ADDR, LEN, LEN data bytes. LEN=0 means 256 bytes.
- CMD 0x00 = load ROM; 0x01 = load RAM; 0x02 = RUN (micro_rst<=0); 0x03 = HALT (micro_rst<=1). Any other CMD: err<=1, stay IDLE.
- Accepting any valid CMD clears err in the same edge, unless the CMD itself is invalid.
- Accepting a load CMD forces micro_rst<=1 immediately. A load never overlaps a running core, and RUN must be sent again after the load.
- FSM transitions on each accepted byte:
  - IDLE -> ADDR on a load CMD; mem_sel latched.
  - ADDR -> LEN; address counter = byte.
  - LEN -> DATA; remaining count = byte (0 loads 256).
  - DATA -> DATA while remaining > 1; DATA -> IDLE on the last byte (-> CSUM with the option enabled).
  - RUN/HALT stay in IDLE.
- Write latency: data byte accepted at edge N -> wr_en=1 with wr_addr/wr_data/mem_sel stable for exactly the cycle after edge N. wr_en is low otherwise. Back-to-back bytes produce consecutive strobes.
- Address increments by 1 per data byte, wrapping 0xFF -> 0x00; no error on wrap.
- in_valid low pauses the frame indefinitely with no timeout; state and counters hold.
- Reset mid-frame: frame is discarded, outputs return to reset values, and a partially written image stays in memory.

Optional Feature:
- LOADER_CHECKSUM_EN defined: after the last data byte the FSM enters CSUM and accepts one more byte. If (sum of data bytes + checksum byte) mod 256 != 0, then err<=1; otherwise err is unchanged. CSUM -> IDLE. Writes already issued are not undone.
- Undefined: no CSUM state; the frame ends on the last data byte.

Test Plan:
- Release arst, stream 00 10 03 AA BB CC -> three wr_en pulses, mem_sel=0, addr/data 10/AA, 11/BB, 12/CC; busy low after the last; micro_rst stays 1.
- Stream 01 FE 03 11 22 33 -> RAM writes FE/11, FF/22, 00/33 (wrap), mem_sel=1, err=0.
- Send 02 -> micro_rst falls one edge later. Then send 00 40 01 5A -> micro_rst rises on CMD acceptance and one ROM write 40/5A occurs.
- Send 07 -> err=1, no wr_en, state stays IDLE. Then send 03 -> err=0, micro_rst=1.
- Load 00 00 00 followed by 256 bytes 0..255 with in_valid toggling every other cycle -> exactly 256 strobes, data==addr, no lost bytes.
- Assert arst after 00 20 04 AA -> one write at 20, all outputs at reset values. Then 01 00 01 77 completes normally. With LOADER_CHECKSUM_EN, 00 00 02 01 02 FD -> err=0, and 00 00 02 01 02 00 -> err=1.

Source files
------------

// File: rtl/prog_loader_if.sv
// Host stream and memory write port of the program loader.
//   in_data/in_valid/in_ready : host byte stream (valid/ready handshake)
//   mem_sel/wr_addr/wr_data/wr_en : write port to the ROM (mem_sel=0) or RAM (mem_sel=1)
// slave modport is the loader side; master modport is the host/memory side.
interface prog_loader_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_sel;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_en;

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_sel, wr_addr, wr_data, wr_en
   );

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_sel, wr_addr, wr_data, wr_en
   );
endinterface

// File: rtl/prog_loader.sv
// Byte-stream loader: writes ROM/RAM images from a host link and controls
// the micro's reset so the core never runs while memory is being loaded.
// Frame: CMD [ADDR LEN DATA*LEN [CSUM]]; CMD 00=load ROM, 01=load RAM,
// 02=RUN, 03=HALT; LEN=0 means 256 bytes.
// Ports:
//   clk       : system clock, rising edge
//   arst      : asynchronous reset, active-low
//   bus       : prog_loader_if.slave (host stream + memory write port)
//   micro_rst : active-high reset to the micro
//   busy      : high whenever a frame is in progress
//   err       : sticky protocol error flag
// Build option: define LOADER_CHECKSUM_EN to append a checksum byte to each
// load frame (data bytes + checksum must sum to 0 mod 256, else err is set).
module prog_loader #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic         clk,
   input  logic         arst,
   prog_loader_if.slave bus,
   output logic         micro_rst,
   output logic         busy,
   output logic         err
);

   localparam logic [DATA_W-1:0] CMD_LOAD_ROM = DATA_W'(0);
   localparam logic [DATA_W-1:0] CMD_LOAD_RAM = DATA_W'(1);
   localparam logic [DATA_W-1:0] CMD_RUN      = DATA_W'(2);
   localparam logic [DATA_W-1:0] CMD_HALT     = DATA_W'(3);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LEN,
      ST_DATA
`ifdef LOADER_CHECKSUM_EN
      , ST_CSUM
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   // Holds (bytes still to load - 1); the last data byte is seen at zero.
   logic [DATA_W-1:0] rem_q, rem_d;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
`endif
   logic              in_ready_q;
   logic              mem_sel_q, mem_sel_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              wr_en_d;
   logic              wr_en_q;
   logic              micro_rst_d;
   logic              err_d;
   logic              accept;

   assign accept       = bus.in_valid & in_ready_q;
   assign bus.in_ready = in_ready_q;
   assign bus.mem_sel  = mem_sel_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.wr_en    = wr_en_q;

   // State and registered outputs
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= '0;
`endif
         in_ready_q <= 1'b0;
         mem_sel_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_en_q    <= 1'b0;
         micro_rst  <= 1'b1;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
         in_ready_q <= 1'b1;
         mem_sel_q  <= mem_sel_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_en_q    <= wr_en_d;
         micro_rst  <= micro_rst_d;
         busy       <= (state_d != ST_IDLE);
         err        <= err_d;
      end
   end

   // Next state and next output values, advanced once per accepted byte
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      mem_sel_d   = mem_sel_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_en_d     = 1'b0;
      micro_rst_d = micro_rst;
      err_d       = err;

      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               case (bus.in_data)
                  CMD_LOAD_ROM, CMD_LOAD_RAM: begin
                     // Loading always holds the core in reset
                     state_d     = ST_ADDR;
                     mem_sel_d   = (bus.in_data == CMD_LOAD_RAM);
                     micro_rst_d = 1'b1;
                     err_d       = 1'b0;
                  end
                  CMD_RUN: begin
                     micro_rst_d = 1'b0;
                     err_d       = 1'b0;
                  end
                  CMD_HALT: begin
                     micro_rst_d = 1'b1;
                     err_d       = 1'b0;
                  end
                  default: err_d = 1'b1;
               endcase
            end
            ST_ADDR: begin
               addr_d  = ADDR_W'(bus.in_data);
               state_d = ST_LEN;
            end
            ST_LEN: begin
               // LEN=0 wraps to all-ones, giving 256 data bytes
               rem_d   = bus.in_data - DATA_W'(1);
`ifdef LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
               state_d = ST_DATA;
            end
            ST_DATA: begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = bus.in_data;
               addr_d    = addr_q + ADDR_W'(1);
               rem_d     = rem_q - DATA_W'(1);
`ifdef LOADER_CHECKSUM_EN
               sum_d     = sum_q + bus.in_data;
`endif
               if (rem_q == '0) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_IDLE;
`endif
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (DATA_W'(sum_q + bus.in_data) != '0) begin
                  err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a command/response vector table, hand
// sequences for reset, pause, wrap and 256-byte loads, and randomized frames
// checked against a frame-level reference model.
module tb_prog_loader;

   logic clk;
   logic arst;
   logic micro_rst;
   logic busy;
   logic err;

   prog_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk       (clk),
      .arst      (arst),
      .bus       (bus),
      .micro_rst (micro_rst),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       sel;
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      logic [7:0] d;
      logic       err;
      logic       rst;
      logic       busy;
      logic       wr;
      logic       sel;
      logic [7:0] addr;
      logic [7:0] wdata;
   } vec_t;

   int         tests = 0;
   int         fails = 0;
   wr_t        got_q[$];
   wr_t        exp_q[$];
   vec_t       vecs[$];
   logic [7:0] frame_q[$];
   logic       m_err;
   logic       m_run;

   // Capture every write strobe
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) got_q.push_back(wr_t'{bus.mem_sel, bus.wr_addr, bus.wr_data});
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add_vec(input logic [7:0] d, input logic e, input logic r,
                                   input logic b, input logic w, input logic s,
                                   input logic [7:0] a, input logic [7:0] wd);
      vec_t v;
      v.d = d; v.err = e; v.rst = r; v.busy = b; v.wr = w; v.sel = s; v.addr = a; v.wdata = wd;
      vecs.push_back(v);
   endfunction

   // Present one byte after 'gap' idle cycles; returns 1ns after the accepting edge
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      @(negedge clk);
      if (gap > 0) begin
         bus.in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus.in_ready !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL in_ready_timeout: got %b expected 1", bus.in_ready);
         bus.in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Reference model: effect of one complete frame held in frame_q
   task automatic model_frame();
      logic [7:0] cmd;
      logic [7:0] sum;
      int         n;
      cmd = frame_q[0];
      if (cmd == 8'h00 || cmd == 8'h01) begin
         m_run = 1'b0;
         m_err = 1'b0;
         n = (frame_q[2] == 8'h00) ? 256 : int'(frame_q[2]);
         sum = 8'h00;
         for (int i = 0; i < n; i++) begin
            exp_q.push_back(wr_t'{cmd[0], 8'((int'(frame_q[1]) + i) % 256), frame_q[3 + i]});
            sum = 8'((int'(sum) + int'(frame_q[3 + i])) % 256);
         end
`ifdef LOADER_CHECKSUM_EN
         if ((int'(sum) + int'(frame_q[3 + n])) % 256 != 0) m_err = 1'b1;
`endif
      end else if (cmd == 8'h02) begin
         m_run = 1'b1;
         m_err = 1'b0;
      end else if (cmd == 8'h03) begin
         m_run = 1'b0;
         m_err = 1'b0;
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic send_frame(input int maxgap);
      for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], int'($urandom_range(0, maxgap)));
      model_frame();
   endtask

   // Append checksum byte (correct when good=1) for the load frame in frame_q
   task automatic add_csum(input bit good);
`ifdef LOADER_CHECKSUM_EN
      int s;
      s = 0;
      for (int i = 3; i < frame_q.size(); i++) s += int'(frame_q[i]);
      if (good) frame_q.push_back(8'((256 - (s % 256)) % 256));
      else      frame_q.push_back(8'(((256 - (s % 256)) % 256 + int'($urandom_range(1, 255))) % 256));
`else
      if (good) begin end
`endif
   endtask

   task automatic compare_writes(input string name);
      chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk({name, "_write"}, 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_state(input string name);
      chk({name, "_err"}, 32'(err), 32'(m_err));
      chk({name, "_micro_rst"}, 32'(micro_rst), 32'(!m_run));
      chk({name, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic check_reset_values(input string name);
      chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({name, "_wr_en"}, 32'(bus.wr_en), 32'd0);
      chk({name, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
      chk({name, "_wr_data"}, 32'(bus.wr_data), 32'd0);
      chk({name, "_mem_sel"}, 32'(bus.mem_sel), 32'd0);
      chk({name, "_micro_rst"}, 32'(micro_rst), 32'd1);
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      int cnt;
      int bad;
      arst         = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      m_err        = 1'b0;
      m_run        = 1'b0;

      // Vector table: byte sent, then err/micro_rst/busy/wr_en/sel/addr/data after its edge
      add_vec(8'h00, 0, 1, 1, 0, 0, 8'h00, 8'h00);
      add_vec(8'h10, 0, 1, 1, 0, 0, 8'h00, 8'h00);
      add_vec(8'h03, 0, 1, 1, 0, 0, 8'h00, 8'h00);
      add_vec(8'hAA, 0, 1, 1, 1, 0, 8'h10, 8'hAA);
      add_vec(8'hBB, 0, 1, 1, 1, 0, 8'h11, 8'hBB);
`ifdef LOADER_CHECKSUM_EN
      add_vec(8'hCC, 0, 1, 1, 1, 0, 8'h12, 8'hCC);
      add_vec(8'hCF, 0, 1, 0, 0, 0, 8'h00, 8'h00);
`else
      add_vec(8'hCC, 0, 1, 0, 1, 0, 8'h12, 8'hCC);
`endif
      add_vec(8'h02, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      add_vec(8'h07, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      add_vec(8'h03, 0, 1, 0, 0, 0, 8'h00, 8'h00);
      add_vec(8'hFF, 1, 1, 0, 0, 0, 8'h00, 8'h00);
      add_vec(8'h02, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      add_vec(8'h80, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      add_vec(8'h01, 0, 1, 1, 0, 0, 8'h00, 8'h00);
      add_vec(8'hFE, 0, 1, 1, 0, 0, 8'h00, 8'h00);
      add_vec(8'h03, 0, 1, 1, 0, 0, 8'h00, 8'h00);
      add_vec(8'h11, 0, 1, 1, 1, 1, 8'hFE, 8'h11);
      add_vec(8'h22, 0, 1, 1, 1, 1, 8'hFF, 8'h22);
`ifdef LOADER_CHECKSUM_EN
      add_vec(8'h33, 0, 1, 1, 1, 1, 8'h00, 8'h33);
      add_vec(8'h9A, 0, 1, 0, 0, 0, 8'h00, 8'h00);
`else
      add_vec(8'h33, 0, 1, 0, 1, 1, 8'h00, 8'h33);
`endif
      add_vec(8'h03, 0, 1, 0, 0, 0, 8'h00, 8'h00);

      // Reset state, then in_ready rises on the first edge after release
      repeat (3) @(negedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      arst = 1'b1;
      #1;
      chk("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("in_ready_after_edge", 32'(bus.in_ready), 32'd1);

      // Table-driven command/response vectors
      foreach (vecs[i]) begin
         send_byte(vecs[i].d, 0);
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
         chk($sformatf("vec%0d_micro_rst", i), 32'(micro_rst), 32'(vecs[i].rst));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         chk($sformatf("vec%0d_wr_en", i), 32'(bus.wr_en), 32'(vecs[i].wr));
         if (vecs[i].wr) begin
            chk($sformatf("vec%0d_mem_sel", i), 32'(bus.mem_sel), 32'(vecs[i].sel));
            chk($sformatf("vec%0d_wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_wr_data", i), 32'(bus.wr_data), 32'(vecs[i].wdata));
         end
      end
      idle(2);
      chk("table_strobe_count", 32'(got_q.size()), 32'd6);
      got_q.delete();
      m_err = 1'b0;
      m_run = 1'b0;

      // RUN, then a load re-asserts micro_rst on CMD acceptance
      send_byte(8'h02, 0);
      chk("run_micro_rst", 32'(micro_rst), 32'd0);
      send_byte(8'h00, 0);
      chk("load_cmd_micro_rst", 32'(micro_rst), 32'd1);
      frame_q = '{8'h00, 8'h40, 8'h01, 8'h5A};
      add_csum(1);
      for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i], 0);
      model_frame();
      idle(2);
      compare_writes("run_then_load");
      check_state("run_then_load");

      // Pause mid-frame: state holds, no strobes
      send_byte(8'h01, 0);
      send_byte(8'h30, 0);
      send_byte(8'h02, 0);
      idle(20);
      chk("pause_busy", 32'(busy), 32'd1);
      chk("pause_no_writes", 32'(got_q.size()), 32'd0);
      frame_q = '{8'h01, 8'h30, 8'h02, 8'h44, 8'h55};
      add_csum(1);
      for (int i = 3; i < frame_q.size(); i++) send_byte(frame_q[i], 3);
      model_frame();
      idle(2);
      compare_writes("pause");
      check_state("pause");

      // 256-byte load (LEN=0) with in_valid toggling
      frame_q = '{8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 256; i++) frame_q.push_back(8'(i));
      add_csum(1);
      for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 1);
      model_frame();
      idle(2);
      cnt = got_q.size();
      bad = 0;
      foreach (got_q[i]) if (got_q[i].addr != got_q[i].data) bad++;
      chk("load256_strobes", 32'(cnt), 32'd256);
      chk("load256_data_eq_addr", 32'(bad), 32'd0);
      compare_writes("load256");
      check_state("load256");

      // Reset mid-frame
      frame_q = '{8'h00, 8'h20, 8'h04, 8'hAA};
      foreach (frame_q[i]) send_byte(frame_q[i], 0);
      idle(2);
      chk("rst_mid_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk("rst_mid_write", 32'(got_q[0]), 32'(wr_t'{1'b0, 8'h20, 8'hAA}));
      got_q.delete();
      arst = 1'b0;
      #1;
      check_reset_values("rst_mid");
      repeat (2) @(negedge clk);
      arst = 1'b1;
      m_err = 1'b0;
      m_run = 1'b0;
      frame_q = '{8'h01, 8'h00, 8'h01, 8'h77};
      add_csum(1);
      send_frame(0);
      idle(2);
      compare_writes("after_rst");
      check_state("after_rst");

`ifdef LOADER_CHECKSUM_EN
      // Checksum pass and fail
      frame_q = '{8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'hFD};
      send_frame(0);
      idle(2);
      chk("csum_good_err", 32'(err), 32'd0);
      compare_writes("csum_good");
      frame_q = '{8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h00};
      send_frame(0);
      idle(2);
      chk("csum_bad_err", 32'(err), 32'd1);
      compare_writes("csum_bad");
      check_state("csum_bad");
`endif

      // Randomized frames against the reference model
      for (int k = 0; k < 60; k++) begin
         int r;
         int len;
         int n;
         frame_q.delete();
         r = int'($urandom_range(0, 9));
         if (r <= 5) begin
            frame_q.push_back(8'($urandom_range(0, 1)));
            frame_q.push_back(8'($urandom));
            len = (k % 20 == 7) ? 0 : int'($urandom_range(1, 10));
            frame_q.push_back(8'(len));
            n = (len == 0) ? 256 : len;
            for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
            add_csum($urandom_range(0, 2) != 0);
         end else if (r == 6) begin
            frame_q.push_back(8'h02);
         end else if (r == 7) begin
            frame_q.push_back(8'h03);
         end else begin
            frame_q.push_back(8'($urandom_range(4, 255)));
         end
         send_frame((k % 7 == 0) ? 12 : 2);
         idle(2);
         compare_writes($sformatf("rand%0d", k));
         check_state($sformatf("rand%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
